// File: rtl/bus_master_arbiter_if.sv
// ============================================================
// bus_master_arbiter_if: fetch/data request ports and shared downstream bus
// Rev 1.0
// ============================================================
`default_nettype none

interface bus_master_arbiter_if;
  logic        i_read;
  logic [9:0]  i_address;
  logic        i_ready;
  logic [31:0] i_readdata;
  logic        i_err;

  logic        d_read;
  logic        d_write;
  logic [3:0]  d_byte_enable;
  logic [9:0]  d_address;
  logic [31:0] d_writedata;
  logic        d_ready;
  logic [31:0] d_readdata;
  logic        d_err;

  logic        bus_read;
  logic        bus_write;
  logic [3:0]  bus_byte_enable;
  logic [9:0]  bus_address;
  logic [31:0] bus_writedata;
  logic [31:0] bus_readdata;
  logic        bus_ready;
  logic [1:0]  grant;

  // master: the arbiter's view; slave: requesters plus downstream
  modport master (
    input  i_read, i_address,
    input  d_read, d_write, d_byte_enable, d_address, d_writedata,
    input  bus_readdata, bus_ready,
    output i_ready, i_readdata, i_err,
    output d_ready, d_readdata, d_err,
    output bus_read, bus_write, bus_byte_enable, bus_address, bus_writedata,
    output grant
  );

  modport slave (
    output i_read, i_address,
    output d_read, d_write, d_byte_enable, d_address, d_writedata,
    output bus_readdata, bus_ready,
    input  i_ready, i_readdata, i_err,
    input  d_ready, d_readdata, d_err,
    input  bus_read, bus_write, bus_byte_enable, bus_address, bus_writedata,
    input  grant
  );
endinterface

`default_nettype wire

// File: rtl/bus_master_arbiter.sv
// ============================================================
// bus_master_arbiter: round-robin fetch/data bus arbiter with timeout
// Rev 1.0
// ============================================================
`default_nettype none

module bus_master_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  wire logic             clk,
  input  wire logic             rst,
  bus_master_arbiter_if.master  bif
);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_BUSY    = 2'd1;
  localparam logic [1:0] c_RECOVER = 2'd2;
  localparam logic [7:0] c_TERM    = 8'(TIMEOUT - 1);

  logic [1:0]  r_state;
  logic [1:0]  w_next_state;
  logic [7:0]  r_cnt;
  logic        r_prio_d_last;
  logic        r_owner_d;
  logic        r_cmd_read;
  logic        r_cmd_write;
  logic [9:0]  r_cmd_addr;
  logic [3:0]  r_cmd_be;
  logic [31:0] r_cmd_wdata;
  logic [31:0] r_i_rdata;
  logic [31:0] r_d_rdata;
  logic        r_i_err;
  logic        r_d_err;

  logic w_i_req;
  logic w_d_req;
  logic w_pick_d;
  logic w_done;
  logic w_abort;

  assign w_i_req  = bif.i_read;
  assign w_d_req  = bif.d_read | bif.d_write;
  assign w_pick_d = w_d_req & (~w_i_req | ~r_prio_d_last);
  assign w_done   = (r_state == c_BUSY) & bif.bus_ready;
  assign w_abort  = (r_state == c_BUSY) & ~bif.bus_ready & (r_cnt == c_TERM);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE:    if (w_i_req | w_d_req) w_next_state = c_BUSY;
      c_BUSY:    if (w_done | w_abort)  w_next_state = c_RECOVER;
      c_RECOVER: w_next_state = c_IDLE;
      default:   w_next_state = c_IDLE;
    endcase
  end

  // Command is masked by bus_ready combinationally so downstream never re-samples it
  always_comb begin
    bif.bus_read        = (r_state == c_BUSY) & r_cmd_read  & ~bif.bus_ready;
    bif.bus_write       = (r_state == c_BUSY) & r_cmd_write & ~bif.bus_ready;
    bif.bus_address     = r_cmd_addr;
    bif.bus_byte_enable = r_cmd_be;
    bif.bus_writedata   = r_cmd_wdata;
    bif.grant           = 2'b00;
    if (r_state != c_IDLE) begin
      bif.grant = r_owner_d ? 2'b10 : 2'b01;
    end
    bif.i_ready         = (r_state == c_RECOVER) & ~r_owner_d;
    bif.d_ready         = (r_state == c_RECOVER) &  r_owner_d;
    bif.i_readdata      = r_i_rdata;
    bif.d_readdata      = r_d_rdata;
    bif.i_err           = r_i_err;
    bif.d_err           = r_d_err;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt         <= 8'd0;
      r_prio_d_last <= 1'b1;
      r_owner_d     <= 1'b0;
      r_cmd_read    <= 1'b0;
      r_cmd_write   <= 1'b0;
      r_cmd_addr    <= 10'd0;
      r_cmd_be      <= 4'd0;
      r_cmd_wdata   <= 32'd0;
      r_i_rdata     <= 32'd0;
      r_d_rdata     <= 32'd0;
      r_i_err       <= 1'b0;
      r_d_err       <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          r_cnt <= 8'd0;
          if (w_i_req | w_d_req) begin
            r_owner_d <= w_pick_d;
            if (w_pick_d) begin
              r_cmd_addr  <= bif.d_address;
              r_cmd_be    <= bif.d_byte_enable;
              r_cmd_wdata <= bif.d_writedata;
              r_cmd_read  <= bif.d_read & ~bif.d_write;
              r_cmd_write <= bif.d_write;
            end else begin
              r_cmd_addr  <= bif.i_address;
              r_cmd_be    <= 4'hF;
              r_cmd_wdata <= 32'd0;
              r_cmd_read  <= 1'b1;
              r_cmd_write <= 1'b0;
            end
          end
        end
        c_BUSY: begin
          r_cnt <= r_cnt + 8'd1;
          if (w_done | w_abort) begin
            r_prio_d_last <= r_owner_d;
            if (r_owner_d) begin
              r_d_err <= w_abort;
              if (r_cmd_read) r_d_rdata <= w_done ? bif.bus_readdata : 32'd0;
            end else begin
              r_i_err <= w_abort;
              if (r_cmd_read) r_i_rdata <= w_done ? bif.bus_readdata : 32'd0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/bus_master_arbiter.md
# bus_master_arbiter

Two-master arbiter that shares the single CPU-facing memory bus between the instruction-fetch port and the load/store port of the RISC-V core. It sits between the core and the address-decoding bus arbitrator that fronts RAM (0x00–0x7f), SW (0x80–0x8f) and LEDR (0x90–0x9f). It provides:
- round-robin granting
- command gating, so the downstream never re-samples a finished command
- a timeout that releases a requester whose address decodes to no device.

## Interface
- TIMEOUT, 64: cycles in BUSY without bus_ready before abort; legal range 4–255.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- i_read  in  1  instruction-fetch read request; held until i_ready.
- i_address  in  10  instruction byte address.
- i_ready  out  1  one-cycle completion pulse to fetch port.
- i_readdata  out  32  fetched word; holds until next fetch completion.
- i_err  out  1  valid with i_ready; 1 means timed out.
- d_read, d_write  in  1 each  load/store request; held until d_ready.
- d_byte_enable  in  4  store/load byte lanes.
- d_address  in  10  data byte address.
- d_writedata  in  32  store data.
- d_ready  out  1  one-cycle completion pulse to data port.
- d_readdata  out  32  load result; holds until next data completion.
- d_err  out  1  valid with d_ready; 1 means timed out.
- bus_read, bus_write  out  1 each  downstream command.
- bus_byte_enable  out  4  downstream byte lanes.
- bus_address  out  10  downstream byte address.
- bus_writedata  out  32  downstream write data.
- bus_readdata  in  32  downstream read data, valid with bus_ready.
- bus_ready  in  1  downstream one-cycle completion pulse.
- grant  out  2  01 = fetch owns bus, 10 = data owns bus, 00 = none.

## Operation

States: IDLE, BUSY, RECOVER.

IDLE:
- Requests are i_read and (d_read | d_write).
- Only one port requesting: that port wins.
- Both requesting: the port not granted last wins. The priority flag resets to "data granted last", so the first tie goes to fetch.
- The winner's address, byte enable, write data and command are latched into command registers. Go to BUSY.
- Fetch commands: byte enable 4'hF, write 0.
- d_read and d_write both high: treated as a write.

BUSY:
- bus_read = cmd_read & ~bus_ready; bus_write = cmd_write & ~bus_ready. This mask is combinational, so the command drops in the same cycle as bus_ready.
- Address, byte enable and write data come from the latched registers and stay constant for the whole BUSY phase.
- The wait counter increments each BUSY cycle.
- Completion on bus_ready = 1:
  - bus_readdata is captured into the winner's readdata register (reads only; writes leave it unchanged).
  - The winner's err is set to 0.
  - The priority flag is updated.
  - Go to RECOVER.
- Abort when the counter reaches TIMEOUT-1 and bus_ready = 0:
  - The winner's readdata is set to 32'h0 (reads only) and its err to 1.
  - The priority flag is updated.
  - Go to RECOVER.
- bus_ready arriving on the terminal count cycle counts as completion, not abort.

RECOVER:
- The winner's ready is 1 for exactly this cycle. The bus command is 0. Go to IDLE.
- A requester may drop or change its request at the clock edge that ends RECOVER.

The other port's request is ignored until IDLE; it is never dropped or reordered. bus_ready while in IDLE or RECOVER is ignored.

## Timing

Reset (rst sampled high at a clock edge) clears:
- state to IDLE, counter to 0, priority flag to "data granted last"
- grant, all command outputs, i_ready, d_ready, i_err, d_err, i_readdata and d_readdata to 0.

Reset mid-BUSY abandons the transfer with no ready pulse, and the command drops on the next cycle.

Latency:
- Request seen in IDLE at cycle N: command on the bus in cycle N+1.
- bus_ready in cycle M: requester ready in cycle M+1; next grant decision in cycle M+2.
- Back-to-back transfers occupy the bus for at most one cycle in every (downstream latency + 2).
- Timeout abort: ready exactly TIMEOUT+1 cycles after the request was sampled in IDLE.
- grant equals the latched winner during BUSY and RECOVER, and 00 in IDLE.

## Test plan
- Single fetch: i_read = 1, i_address = 0x10, RAM word = 0x00500093 -> bus_read for one BUSY phase, bus_read drops in the same cycle as bus_ready, i_ready pulses once, i_readdata = 0x00500093, i_err = 0, d_ready stays 0.
- Store then load: d_write to 0x94 with d_byte_enable 4'hF and d_writedata 0x2A -> bus_write with exactly those values. Then d_read of 0x94 -> d_readdata reflects the LEDR read, one d_ready per transfer.
- Simultaneous requests: i_read and d_read held high for 4 transfers after reset -> grant sequence 01, 10, 01, 10, with exactly one ready pulse per port per grant.
- Unmapped address: d_read at 0x3F0 with no bus_ready -> bus_read drops after TIMEOUT (64) BUSY cycles, d_ready = 1 with d_err = 1, d_readdata = 0, and the next fetch is serviced normally.
- Ready on terminal count: bus_ready forced in BUSY cycle TIMEOUT-1 -> completion with err = 0 and captured readdata.
- Reset mid-BUSY: rst asserted during a write -> the next cycle shows all outputs 0 and state IDLE, no ready pulse, and the first later tie goes to fetch.
